// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace unit: the 5-word record, serializer states
// and the w0 header packing.
package rvfi_trace_pkg;

  localparam int REC_WORDS = 5;

  // w0 sits in the top word so the serializer can shift toward the MSB.
  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] w4;
  } trace_rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Bit 0 is always set so a sink can resynchronize on it after trace_last.
  function automatic logic [31:0] pack_w0(
    input logic [63:0] order,
    input logic        trap,
    input logic        halt,
    input logic [3:0]  rmask,
    input logic [3:0]  wmask,
    input logic [4:0]  rd_addr
  );
    return {order[15:0], trap, halt, rmask, wmask, rd_addr, 1'b1};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a push while
// full is accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rvfi_trace_unit.sv
// Captures RVFI retirements, checks order/PC continuity, buffers them and
// serializes each as five 32-bit words on a valid/ready trace stream.
module rvfi_trace_unit
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_data,
  output logic        trace_last,
  output logic        err_order,
  output logic        err_pc,
  output logic [15:0] drop_count,
  output logic        halted,
  output ser_state_t  dbg_state
);

  // Trace stream handshake: a word transfers on a rising clk edge where
  // trace_valid & trace_ready; while trace_valid & ~trace_ready the word,
  // trace_data and trace_last hold unchanged.

  trace_rec_t rec_in;
  trace_rec_t rec_out;
  trace_rec_t shreg;
  ser_state_t state;
  logic [2:0]  idx;
  logic        cap;
  logic        drop;
  logic        ser_pop;
  logic        last_word;
  logic        fifo_full;
  logic        fifo_empty;
  logic        have_prev;
  logic [63:0] prev_order;
  logic [31:0] prev_pc_wdata;

  assign cap       = rvfi_valid & ~halted;
  assign last_word = (idx == 3'(REC_WORDS - 1));
  assign ser_pop   = (state == IDLE) ? ~fifo_empty : (trace_ready & last_word & ~fifo_empty);
  assign drop      = cap & fifo_full & ~ser_pop;
  assign trace_data = shreg.w0;
  assign dbg_state  = state;

  assign rec_in = '{
    w0: pack_w0(rvfi_order, rvfi_trap, rvfi_halt, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_rd_addr),
    w1: rvfi_pc_rdata,
    w2: rvfi_insn,
    w3: rvfi_rd_wdata,
    w4: rvfi_mem_addr
  };

  trace_fifo #(.DEPTH(DEPTH), .T(trace_rec_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cap),
    .wr_data (rec_in),
    .pop     (ser_pop),
    .rd_data (rec_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Checker state tracks every captured retirement, dropped or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_prev     <= 1'b0;
      prev_order    <= '0;
      prev_pc_wdata <= '0;
      err_order     <= 1'b0;
      err_pc        <= 1'b0;
      halted        <= 1'b0;
      drop_count    <= '0;
    end else if (cap) begin
      have_prev     <= 1'b1;
      prev_order    <= rvfi_order;
      prev_pc_wdata <= rvfi_pc_wdata;
      if (have_prev && (rvfi_order != prev_order + 64'd1)) err_order <= 1'b1;
      if (have_prev && (rvfi_pc_rdata != prev_pc_wdata))   err_pc    <= 1'b1;
      if (rvfi_halt) halted <= 1'b1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      shreg       <= '0;
      trace_valid <= 1'b0;
      trace_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg       <= rec_out;
            idx         <= '0;
            trace_valid <= 1'b1;
            trace_last  <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (trace_ready) begin
            if (!last_word) begin
              shreg      <= trace_rec_t'({shreg[127:0], 32'h0});
              idx        <= idx + 3'd1;
              trace_last <= (idx == 3'(REC_WORDS - 2));
            end else if (!fifo_empty) begin
              shreg      <= rec_out;
              idx        <= '0;
              trace_last <= 1'b0;
            end else begin
              shreg       <= '0;
              idx         <= '0;
              trace_valid <= 1'b0;
              trace_last  <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_trace_unit.sv
// Directed + randomized bench for rvfi_trace_unit with a word-level reference
// model and an expected-word scoreboard.
module tb_rvfi_trace_unit;
  import rvfi_trace_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [31:0] rvfi_mem_addr = '0;
  logic [3:0]  rvfi_mem_rmask = '0;
  logic [3:0]  rvfi_mem_wmask = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trace_last;
  logic        err_order;
  logic        err_pc;
  logic [15:0] drop_count;
  logic        halted;
  ser_state_t  dbg_state;

  rvfi_trace_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_last(trace_last),
    .err_order(err_order), .err_pc(err_pc), .drop_count(drop_count),
    .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  int tests = 0;
  int fails = 0;
  int rec_done = 0;
  int done_base = 0;
  int m_acc = 0;
  logic        m_have_prev = 1'b0;
  logic [63:0] m_prev_order = '0;
  logic [31:0] m_prev_npc = '0;
  logic        m_err_order = 1'b0;
  logic        m_err_pc = 1'b0;
  logic        m_halted = 1'b0;
  int          m_drop = 0;
  logic        rand_ready = 1'b0;
  logic [63:0] cur_order = '0;
  logic [31:0] cur_pc = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; the retirement is captured at the next posedge.
  task automatic retire(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] wdata,
                        input logic [31:0] maddr, input logic [3:0] rmask, input logic [3:0] wmask,
                        input logic trap, input logic halt);
    int in_unit;
    rvfi_valid = 1'b1; rvfi_order = order; rvfi_pc_rdata = pc; rvfi_pc_wdata = npc;
    rvfi_insn = insn; rvfi_rd_addr = rd; rvfi_rd_wdata = wdata; rvfi_mem_addr = maddr;
    rvfi_mem_rmask = rmask; rvfi_mem_wmask = wmask; rvfi_trap = trap; rvfi_halt = halt;
    if (!m_halted) begin
      if (m_have_prev && order != m_prev_order + 64'd1) m_err_order = 1'b1;
      if (m_have_prev && pc != m_prev_npc) m_err_pc = 1'b1;
      m_have_prev = 1'b1; m_prev_order = order; m_prev_npc = npc;
      // The unit holds DEPTH records in the FIFO plus one in the serializer.
      in_unit = m_acc - (rec_done - done_base);
      if (in_unit < DEPTH + 1) begin
        exp_q.push_back({order[15:0], trap, halt, rmask, wmask, rd, 1'b1});
        exp_q.push_back(pc);
        exp_q.push_back(insn);
        exp_q.push_back(wdata);
        exp_q.push_back(maddr);
        exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0);
        exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b1);
        m_acc++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      if (halt) m_halted = 1'b1;
    end
    @(posedge clk); #1;
    rvfi_valid = 1'b0; rvfi_halt = 1'b0;
  endtask

  task automatic rand_retire(input logic halt);
    logic [63:0] order;
    logic [31:0] pc;
    order = cur_order + (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd1);
    pc    = ($urandom_range(0, 7) == 0) ? cur_pc + 32'd8 : cur_pc;
    retire(order, pc, pc + 32'd4, $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), halt);
    cur_order = order;
    cur_pc    = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    done_base = rec_done; m_acc = 0;
    m_have_prev = 1'b0; m_err_order = 1'b0; m_err_pc = 1'b0; m_halted = 1'b0; m_drop = 0;
    cur_order = '0; cur_pc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || trace_valid); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, trace_valid, 0);
    chk({tag, "_data"},  trace_data, 0);
    chk({tag, "_last"},  trace_last, 0);
    chk({tag, "_eord"},  err_order, 0);
    chk({tag, "_epc"},   err_pc, 0);
    chk({tag, "_drop"},  drop_count, 0);
    chk({tag, "_halt"},  halted, 0);
  endtask

  // ---------------- random sink readiness ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) trace_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", trace_valid, 1);
        chk("stall_data", trace_data, prev_data);
        chk("stall_last", trace_last, prev_last);
      end
      if (trace_valid && trace_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL extra_word observed=%h expected=none", trace_data);
        end
        if (exp_q.size() != 0) begin
          chk("word", trace_data, exp_q.pop_front());
          if (exp_last_q.pop_front()) begin
            chk("last", trace_last, 1);
            rec_done++;
          end else begin
            chk("last", trace_last, 0);
          end
        end
      end
      prev_stall = trace_valid && !trace_ready;
      prev_data  = trace_data;
      prev_last  = trace_last;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    #2;
    check_outputs_zero("in_reset");
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single retirement, latency N+2, ready held high.
    trace_ready = 1'b1;
    retire(64'd0, 32'h0, 32'h4, 32'h0050_0093, 5'd1, 32'd5, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("lat_n1_valid", trace_valid, 0);
    @(posedge clk); #1;
    chk("lat_n2_valid", trace_valid, 1);
    chk("lat_n2_w0", trace_data, 32'h0000_0003);
    drain("single_drain");
    chk("single_eord", err_order, 0);
    chk("single_epc", err_pc, 0);

    // Order skip, then PC jump; flags must stick.
    retire(64'd2, 32'h4, 32'h8, 32'h0000_0013, 5'd2, 32'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("disc_eord", err_order, m_err_order);
    chk("disc_epc0", err_pc, 0);
    retire(64'd3, 32'h10, 32'h14, 32'h0000_0013, 5'd3, 32'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("disc_epc1", err_pc, 1);
    retire(64'd4, 32'h14, 32'h18, 32'h0000_0013, 5'd4, 32'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("sticky_eord", err_order, 1);
    chk("sticky_epc", err_pc, 1);
    drain("disc_drain");

    // Random traffic with random backpressure.
    cur_order = 64'd4; cur_pc = 32'h18;
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_retire(1'b0);
      repeat ($urandom_range(8, 14)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    trace_ready = 1'b1;
    drain("rand_drain");
    chk("rand_eord", err_order, m_err_order);
    chk("rand_epc", err_pc, m_err_pc);

    // Overflow: 12 back-to-back into a stalled sink.
    do_reset();
    trace_ready = 1'b0;
    base = rec_done;
    for (int n = 0; n < 12; n++) rand_retire(1'b0);
    chk("ovf_drop", drop_count, 3);
    chk("ovf_drop_model", drop_count, m_drop);
    trace_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_records", rec_done - base, 9);

    // Halt: only the halt record appears, later pulses ignored.
    base = rec_done;
    rand_retire(1'b1);
    for (int n = 0; n < 3; n++) rand_retire(1'b0);
    chk("halt_flag", halted, 1);
    chk("halt_drop", drop_count, 3);
    drain("halt_drain");
    chk("halt_records", rec_done - base, 1);

    // Async reset in the middle of a record.
    do_reset();
    trace_ready = 1'b1;
    retire(64'd77, 32'h100, 32'h104, 32'h1234_5678, 5'd7, 32'hCAFE_F00D, 32'hA5A5_0000,
           4'h3, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_w2", trace_data, 32'h1234_5678);
    rst = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    #1;
    check_outputs_zero("async_rst");
    do_reset();
    retire(64'd500, 32'h200, 32'h204, 32'h0010_0113, 5'd2, 32'd1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    drain("post_rst_drain");
    chk("post_rst_eord", err_order, 0);
    chk("post_rst_epc", err_pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
